ddpuf_eval_fsm: RTL and testbench

DDPUF_EVAL_FSM -- requirements
Module: ddpuf_eval_fsm

---
 rtl/ddpuf_eval_fsm.sv | 191 +++++++++++++++++++
 tb/tb_ddpuf_eval_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddpuf_eval_fsm.sv
// ddpuf_eval_fsm
// Sequences repeated evaluations of the DD-PUF cell array and majority-votes
// the per-cell responses into a single 128-bit result.
//
// Each run consists of NUM_EVAL evaluations. Each evaluation is a discharge
// phase (array disabled), an evaluation window (array enabled), and two sample
// cycles while the raw outputs settle through a 2-flop synchronizer. After the
// last evaluation, one vote cycle produces the result.
//
// Ports
//   CLK           sole clock (SPI block CLK_OUT), posedge
//   RST_N         asynchronous active-low reset
//   FSM_Start     run request; its rising edge starts a run when idle or done
//   Duration[15:0] evaluation window length in CLK cycles; 0 is treated as 1
//   PUF_Raw[127:0] raw cell outputs, asynchronous to CLK
//   FSM_Complete  level flag, high from the end of a run until the next accept
//   PUF_Val[127:0] majority-voted response; bit i comes from cell i
//   PUF_En        cell array enable; low means discharge/hold
//   Busy          high while a run is in progress
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | after reset; waiting for a FSM_Start rising edge
// S_DISCHARGE | PUF_En low for RST_CYC cycles before each evaluation
// S_EVAL      | PUF_En high for the latched window length
// S_SAMPLE    | PUF_En high 2 cycles; vote counters updated on the last one
// S_VOTE      | one cycle; majority result registered, run flagged complete
// S_DONE      | result held; waiting for the next FSM_Start rising edge
module ddpuf_eval_fsm #(
    parameter int NUM_EVAL = 5,
    parameter int RST_CYC  = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         FSM_Start,
    input  logic [15:0]  Duration,
    input  logic [127:0] PUF_Raw,
    output logic         FSM_Complete,
    output logic [127:0] PUF_Val,
    output logic         PUF_En,
    output logic         Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCHARGE,
        S_EVAL,
        S_SAMPLE,
        S_VOTE,
        S_DONE
    } state_t;

    // Phase timers are down-counters loaded with (length - 1); the phase ends
    // in the cycle where the count reaches zero.
    localparam logic [15:0] DIS_LOAD  = 16'(RST_CYC - 1);
    localparam logic [15:0] SMP_LOAD  = 16'd1;
    localparam logic [2:0]  LAST_EVAL = 3'(NUM_EVAL - 1);
    localparam logic [2:0]  MAJORITY  = 3'((NUM_EVAL + 1) / 2);

    state_t state_q, state_d;

    logic                start_d_q;
    logic [15:0]         dur_q;
    logic [15:0]         timer_q;
    logic [15:0]         timer_load_val;
    logic                timer_load;
    logic                timer_tc;
    logic                accept;
    logic                sample_fire;
    logic                last_eval;
    logic [2:0]          eval_cnt_q;
    logic [127:0][2:0]   vote_cnt_q;
    logic [127:0]        sync1_q;
    logic [127:0]        sync2_q;
    logic [127:0]        vote_bits;

    // A start edge is only honoured between runs; edges during a run are dropped.
    assign accept      = FSM_Start && !start_d_q &&
                         ((state_q == S_IDLE) || (state_q == S_DONE));
    assign timer_tc    = (timer_q == 16'd0);
    assign last_eval   = (eval_cnt_q == LAST_EVAL);
    assign sample_fire = (state_q == S_SAMPLE) && timer_tc;

    always_comb begin
        state_d        = state_q;
        timer_load     = 1'b0;
        timer_load_val = 16'd0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d        = S_DISCHARGE;
                    timer_load     = 1'b1;
                    timer_load_val = DIS_LOAD;
                end
            end
            S_DISCHARGE: begin
                if (timer_tc) begin
                    state_d        = S_EVAL;
                    timer_load     = 1'b1;
                    timer_load_val = dur_q - 16'd1;
                end
            end
            S_EVAL: begin
                if (timer_tc) begin
                    state_d        = S_SAMPLE;
                    timer_load     = 1'b1;
                    timer_load_val = SMP_LOAD;
                end
            end
            S_SAMPLE: begin
                if (timer_tc) begin
                    if (last_eval) begin
                        state_d = S_VOTE;
                    end else begin
                        state_d        = S_DISCHARGE;
                        timer_load     = 1'b1;
                        timer_load_val = DIS_LOAD;
                    end
                end
            end
            S_VOTE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        vote_bits = '0;
        for (int i = 0; i < 128; i++) begin
            vote_bits[i] = (vote_cnt_q[i] >= MAJORITY);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            start_d_q    <= 1'b0;
            dur_q        <= 16'd1;
            timer_q      <= 16'd0;
            eval_cnt_q   <= 3'd0;
            vote_cnt_q   <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            PUF_Val      <= '0;
            FSM_Complete <= 1'b0;
            PUF_En       <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_d_q <= FSM_Start;
            sync1_q   <= PUF_Raw;
            sync2_q   <= sync1_q;

            // Registered from the next state so the enable lines up exactly
            // with the EVAL/SAMPLE cycles and never glitches.
            PUF_En <= (state_d == S_EVAL) || (state_d == S_SAMPLE);

            if (timer_load) begin
                timer_q <= timer_load_val;
            end else if (!timer_tc) begin
                timer_q <= timer_q - 16'd1;
            end

            if (accept) begin
                dur_q        <= (Duration == 16'd0) ? 16'd1 : Duration;
                eval_cnt_q   <= 3'd0;
                vote_cnt_q   <= '0;
                FSM_Complete <= 1'b0;
                Busy         <= 1'b1;
            end else begin
                if (sample_fire) begin
                    if (!last_eval) begin
                        eval_cnt_q <= eval_cnt_q + 3'd1;
                    end
                    for (int i = 0; i < 128; i++) begin
                        vote_cnt_q[i] <= vote_cnt_q[i] + {2'b00, sync2_q[i]};
                    end
                end
                if (state_q == S_VOTE) begin
                    PUF_Val      <= vote_bits;
                    FSM_Complete <= 1'b1;
                    Busy         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddpuf_eval_fsm.sv
`timescale 1ns/1ps
module tb_ddpuf_eval_fsm;

    localparam int N = 5;
    localparam int R = 4;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         FSM_Start;
    logic [15:0]  Duration;
    logic [127:0] PUF_Raw;
    logic         FSM_Complete;
    logic [127:0] PUF_Val;
    logic         PUF_En;
    logic         Busy;

    int errors = 0;
    int checks = 0;

    logic [127:0] cur_pat [N];
    logic [127:0] prev_val;

    typedef struct packed {
        logic [15:0]          dur;
        logic [N-1:0][127:0]  pat;
        logic [31:0]          lat;
        logic [127:0]         val;
    } vec_t;

    vec_t tbl [6];

    ddpuf_eval_fsm #(.NUM_EVAL(N), .RST_CYC(R)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .FSM_Start    (FSM_Start),
        .Duration     (Duration),
        .FSM_Complete (FSM_Complete),
        .PUF_Val      (PUF_Val),
        .PUF_En       (PUF_En),
        .PUF_Raw      (PUF_Raw),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Majority over the evaluations: a bit is 1 when more than half of the
    // patterns had it set.
    function automatic logic [127:0] vote_model();
        logic [127:0] v;
        int ones;
        v = '0;
        for (int b = 0; b < 128; b++) begin
            ones = 0;
            for (int k = 0; k < N; k++) ones += int'(cur_pat[k][b]);
            v[b] = (2 * ones > N);
        end
        return v;
    endfunction

    // mode 0: FSM_Start pulsed
    // mode 1: FSM_Start held high, Duration changed to 2 mid-run
    // mode 2: FSM_Start pulsed, then a second rising edge while busy
    task automatic run(input logic [15:0] dur, input int mode, input bit pre_high,
                       input int lat_exp, input logic [127:0] val_exp, input string tag);
        int d_eff, p, lat_obs, bad_en, bad_busy, bad_cmp, bad_hold;
        bit exp_en, exp_busy, exp_cmp;
        d_eff = (dur == 16'd0) ? 1 : int'(dur);
        p = R + d_eff + 2;
        lat_obs = -1;
        bad_en = 0; bad_busy = 0; bad_cmp = 0; bad_hold = 0;
        if (!pre_high) begin
            FSM_Start = 1'b0;
            @(posedge CLK); #1;
            FSM_Start = 1'b1;
        end
        Duration = dur;
        PUF_Raw  = cur_pat[0];
        // c counts cycles after the accept edge (c = 0 right after it)
        for (int c = 0; c <= lat_exp + 3; c++) begin
            @(posedge CLK); #1;
            exp_en   = (c < N * p) && ((c % p) >= R);
            exp_busy = (c <= N * p);
            exp_cmp  = (c > N * p);
            if (PUF_En !== exp_en) bad_en++;
            if (Busy !== exp_busy) bad_busy++;
            if (FSM_Complete !== exp_cmp) bad_cmp++;
            if (FSM_Complete === 1'b1 && lat_obs < 0) lat_obs = c;
            if (c <= N * p && PUF_Val !== prev_val) bad_hold++;
            if (c > 0 && (c % p) == 0 && (c / p) < N) PUF_Raw = cur_pat[c / p];
            case (mode)
                0: if (c == 1) FSM_Start = 1'b0;
                1: if (c == 20) Duration = 16'd2;
                default: begin
                    if (c == 1) FSM_Start = 1'b0;
                    if (c == 3) FSM_Start = 1'b1;
                    if (c == 6) FSM_Start = 1'b0;
                end
            endcase
        end
        chk({tag, " latency"},     128'(lat_obs), 128'(lat_exp));
        chk({tag, " puf_en_shape"}, 128'(bad_en),  128'(0));
        chk({tag, " busy_shape"},  128'(bad_busy), 128'(0));
        chk({tag, " cmp_shape"},   128'(bad_cmp),  128'(0));
        chk({tag, " val_held"},    128'(bad_hold), 128'(0));
        chk({tag, " puf_val"},     PUF_Val, val_exp);
        prev_val = val_exp;
    endtask

    initial begin
        int n_bad, d_eff, mode, lat;
        logic [15:0] dur;

        // ---- table rows: {Duration, per-eval raw patterns, latency, result}
        tbl[0].dur = 16'd10;
        for (int k = 0; k < N; k++) tbl[0].pat[k] = '1;
        tbl[0].lat = 32'd81; tbl[0].val = '1;

        tbl[1].dur = 16'd0;
        for (int k = 0; k < N; k++) tbl[1].pat[k] = {16{8'hA5}};
        tbl[1].lat = 32'd36; tbl[1].val = {16{8'hA5}};

        tbl[2].dur = 16'd3;
        tbl[2].pat[0] = 128'h3; tbl[2].pat[1] = 128'h3; tbl[2].pat[2] = 128'h1;
        tbl[2].pat[3] = 128'h0; tbl[2].pat[4] = 128'h0;
        tbl[2].lat = 32'd46; tbl[2].val = 128'h1;

        tbl[3].dur = 16'd1;
        for (int k = 0; k < N; k++) tbl[3].pat[k] = '0;
        tbl[3].lat = 32'd36; tbl[3].val = '0;

        tbl[4].dur = 16'd2;
        tbl[4].pat[0] = {32{4'hF}}; tbl[4].pat[1] = {32{4'hE}}; tbl[4].pat[2] = {32{4'hC}};
        tbl[4].pat[3] = {32{4'h8}}; tbl[4].pat[4] = '0;
        tbl[4].lat = 32'd41; tbl[4].val = {32{4'hC}};

        tbl[5].dur = 16'd20;
        for (int k = 0; k < N; k++) tbl[5].pat[k] = {4{32'hDEADBEEF}};
        tbl[5].lat = 32'd131; tbl[5].val = {4{32'hDEADBEEF}};

        // ---- reset state, with FSM_Start already high during reset
        RST_N = 1'b0; FSM_Start = 1'b1; Duration = 16'd10; PUF_Raw = '1; prev_val = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst complete", 128'(FSM_Complete), 128'(0));
        chk("rst busy",     128'(Busy),         128'(0));
        chk("rst puf_en",   128'(PUF_En),       128'(0));
        chk("rst puf_val",  PUF_Val,            128'(0));
        RST_N = 1'b1;
        for (int k = 0; k < N; k++) cur_pat[k] = '1;
        run(16'd10, 0, 1'b1, 81, '1, "por_start");

        // ---- table-driven runs
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) cur_pat[k] = tbl[i].pat[k];
            run(tbl[i].dur, 0, 1'b0, int'(tbl[i].lat), tbl[i].val, $sformatf("tbl%0d", i));
        end

        // ---- held start, Duration changed mid-run, then no retrigger
        for (int k = 0; k < N; k++) cur_pat[k] = {8{16'h5A3C}};
        run(16'd10, 1, 1'b0, 81, {8{16'h5A3C}}, "held_start");
        n_bad = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (FSM_Complete !== 1'b1 || Busy !== 1'b0 || PUF_En !== 1'b0 || PUF_Val !== prev_val)
                n_bad++;
        end
        chk("no_retrigger", 128'(n_bad), 128'(0));

        // ---- second rising edge while busy is ignored
        for (int k = 0; k < N; k++) cur_pat[k] = {$urandom, $urandom, $urandom, $urandom};
        run(16'd5, 2, 1'b0, 56, vote_model(), "busy_edge");

        // ---- reset during the third evaluation window
        for (int k = 0; k < N; k++) cur_pat[k] = '1;
        FSM_Start = 1'b0;
        @(posedge CLK); #1;
        FSM_Start = 1'b1; Duration = 16'd10; PUF_Raw = '1;
        repeat (41) @(posedge CLK);
        #1;
        chk("midrun in_eval", 128'(PUF_En), 128'(1));
        RST_N = 1'b0;
        FSM_Start = 1'b0;
        #1;
        chk("midrun_rst complete", 128'(FSM_Complete), 128'(0));
        chk("midrun_rst busy",     128'(Busy),         128'(0));
        chk("midrun_rst puf_en",   128'(PUF_En),       128'(0));
        chk("midrun_rst puf_val",  PUF_Val,            128'(0));
        prev_val = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("post_rst idle busy", 128'(Busy), 128'(0));
        cur_pat[0] = '1; cur_pat[1] = '1; cur_pat[2] = '0; cur_pat[3] = '0; cur_pat[4] = '0;
        run(16'd10, 0, 1'b0, 81, '0, "post_rst");

        // ---- randomized runs against the majority model
        for (int i = 0; i < 6; i++) begin
            dur = 16'($urandom_range(0, 12));
            d_eff = (dur == 16'd0) ? 1 : int'(dur);
            mode = int'($urandom_range(0, 2));
            lat = N * (R + d_eff + 2) + 1;
            for (int k = 0; k < N; k++) cur_pat[k] = {$urandom, $urandom, $urandom, $urandom};
            run(dur, mode, 1'b0, lat, vote_model(), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
